// File: rtl/harvos_dmem_arb.sv
// rtl/harvos_dmem_arb.sv - two-master round-robin arbiter for the shared data-memory port
// Ports: clk, rst (async, active-high)
//        m0_* core LSU / m1_* debug module: req_valid/ready, addr, we, wdata, be; rsp_valid, rsp_rdata, rsp_err
//        mem_*: req_valid/ready, addr, we, wdata, be to memory; rsp_valid, rsp_rdata, rsp_err from memory
//        busy (not IDLE), timeout_o (forced error response), stray_rsp_o (response outside RSP)
module harvos_dmem_arb #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req_valid,
   output logic        m0_req_ready,
   input  logic [31:0] m0_req_addr,
   input  logic        m0_req_we,
   input  logic [31:0] m0_req_wdata,
   input  logic [3:0]  m0_req_be,
   output logic        m0_rsp_valid,
   output logic [31:0] m0_rsp_rdata,
   output logic        m0_rsp_err,
   input  logic        m1_req_valid,
   output logic        m1_req_ready,
   input  logic [31:0] m1_req_addr,
   input  logic        m1_req_we,
   input  logic [31:0] m1_req_wdata,
   input  logic [3:0]  m1_req_be,
   output logic        m1_rsp_valid,
   output logic [31:0] m1_rsp_rdata,
   output logic        m1_rsp_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   input  logic        mem_rsp_err,
   output logic        busy,
   output logic        timeout_o,
   output logic        stray_rsp_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        last_grant_q;
   logic        owner_q;
   logic        hold_q;
   logic [7:0]  cnt_q;
   logic [31:0] addr_q;
   logic        we_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;

   logic        grant0, grant1;
   logic        rsp_fire, to_fire;
   logic        rsp_any;

   always_comb begin
      state_d  = state_q;
      grant0   = 1'b0;
      grant1   = 1'b0;
      rsp_fire = 1'b0;
      to_fire  = 1'b0;
      case (state_q)
         IDLE: begin
            // hold_q blocks arbitration in the first IDLE cycle after a response;
            // rst gating keeps ready low while reset is held
            if (!hold_q && !rst) begin
               if (m1_req_valid && (!m0_req_valid || !last_grant_q)) begin
                  grant1 = 1'b1;
               end else if (m0_req_valid) begin
                  grant0 = 1'b1;
               end
               if (grant0 || grant1) begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               state_d = RSP;
            end
         end
         RSP: begin
            // a real response wins over a timeout landing in the same cycle
            if (mem_rsp_valid) begin
               rsp_fire = 1'b1;
               state_d  = IDLE;
            end else if (cnt_q == TIMEOUT_CNT) begin
               to_fire = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rsp_any = rsp_fire || to_fire;

   always_comb begin
      m0_req_ready  = grant0;
      m1_req_ready  = grant1;
      m0_rsp_valid  = rsp_any && !owner_q;
      m1_rsp_valid  = rsp_any && owner_q;
      // timeout responses carry err=1, rdata=0; idle responders show all zeros
      m0_rsp_rdata  = (m0_rsp_valid && rsp_fire) ? mem_rsp_rdata : 32'd0;
      m1_rsp_rdata  = (m1_rsp_valid && rsp_fire) ? mem_rsp_rdata : 32'd0;
      m0_rsp_err    = m0_rsp_valid && (rsp_fire ? mem_rsp_err : 1'b1);
      m1_rsp_err    = m1_rsp_valid && (rsp_fire ? mem_rsp_err : 1'b1);
      mem_req_valid = (state_q == REQ);
      mem_addr      = mem_req_valid ? addr_q  : 32'd0;
      mem_we        = mem_req_valid ? we_q    : 1'b0;
      mem_wdata     = mem_req_valid ? wdata_q : 32'd0;
      mem_be        = mem_req_valid ? be_q    : 4'd0;
      busy          = (state_q != IDLE);
      timeout_o     = to_fire;
      stray_rsp_o   = mem_rsp_valid && (state_q != RSP) && !rst;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         hold_q       <= 1'b0;
         cnt_q        <= 8'd0;
         addr_q       <= 32'd0;
         we_q         <= 1'b0;
         wdata_q      <= 32'd0;
         be_q         <= 4'd0;
      end else begin
         state_q <= state_d;
         hold_q  <= (state_q == RSP) && (state_d == IDLE);
         if (grant0 || grant1) begin
            last_grant_q <= grant1;
            owner_q      <= grant1;
            addr_q       <= grant1 ? m1_req_addr  : m0_req_addr;
            we_q         <= grant1 ? m1_req_we    : m0_req_we;
            wdata_q      <= grant1 ? m1_req_wdata : m0_req_wdata;
            be_q         <= grant1 ? m1_req_be    : m0_req_be;
         end
         if (state_q == REQ && mem_req_ready) begin
            cnt_q <= 8'd0;
         end else if (state_q == RSP && !mem_rsp_valid && cnt_q != TIMEOUT_CNT) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_harvos_dmem_arb.sv
// tb/tb_harvos_dmem_arb.sv - self-checking bench for harvos_dmem_arb
module tb_harvos_dmem_arb;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
   logic        m0_req_ready, m1_req_ready;
   logic [31:0] m0_req_addr = '0, m1_req_addr = '0;
   logic        m0_req_we = 1'b0, m1_req_we = 1'b0;
   logic [31:0] m0_req_wdata = '0, m1_req_wdata = '0;
   logic [3:0]  m0_req_be = '0, m1_req_be = '0;
   logic        m0_rsp_valid, m1_rsp_valid;
   logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
   logic        m0_rsp_err, m1_rsp_err;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_rdata = '0;
   logic        mem_rsp_err = 1'b0;
   logic        busy, timeout_o, stray_rsp_o;

   int total = 0;
   int bad = 0;
   int cov_tie = 0, cov_to = 0, cov_stray = 0;
   bit last_w = 1'b1;
   bit hold = 1'b0;
   logic [31:0] force_rd = '0;
   logic        p_stall = 1'b0;
   logic [69:0] p_fields = '0;

   harvos_dmem_arb #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
      .m0_req_we(m0_req_we), .m0_req_wdata(m0_req_wdata), .m0_req_be(m0_req_be),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
      .m1_req_we(m1_req_we), .m1_req_wdata(m1_req_wdata), .m1_req_be(m1_req_be),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
      .busy(busy), .timeout_o(timeout_o), .stray_rsp_o(stray_rsp_o)
   );

   always #5 clk = ~clk;

   function automatic logic [142:0] all_outs();
      return {m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
              m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
              mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be,
              busy, timeout_o, stray_rsp_o};
   endfunction

   // always-on properties: one-hot ready, one-hot response, stable stalled request
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (m0_req_ready === 1'b1 && m1_req_ready === 1'b1) begin
            bad++;
            $display("FAIL prop_ready_onehot: got m0=%b m1=%b want not both", m0_req_ready, m1_req_ready);
         end
         total++;
         if (m0_rsp_valid === 1'b1 && m1_rsp_valid === 1'b1) begin
            bad++;
            $display("FAIL prop_rsp_onehot: got m0=%b m1=%b want not both", m0_rsp_valid, m1_rsp_valid);
         end
         if (p_stall) begin
            total++;
            if ({mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be} !== p_fields) begin
               bad++;
               $display("FAIL prop_stall_stable: got %h want %h",
                        {mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be}, p_fields);
            end
         end
         p_stall  = mem_req_valid && !mem_req_ready;
         p_fields = {mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be};
      end else begin
         p_stall = 1'b0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
   endtask

   // one full transaction: v0/v1 request pattern, d stall cycles before mem_req_ready,
   // response in RSP cycle r (r > TO means memory stays silent), optional late response
   task automatic do_txn(input bit v0, input bit v1, input int d, input int r,
                         input bit late, input bit use_rd, input bit inj);
      bit          w;
      bit          done;
      logic [31:0] ea, ewd, rd;
      logic        ewe, re, s;
      logic [3:0]  ebe;
      logic        exp_v, exp_e, exp_t;
      logic [31:0] exp_d;
      logic [33:0] own, oth;
      w = (v0 && v1) ? ~last_w : v1;
      cyc();
      m0_req_valid = v0;
      m1_req_valid = v1;
      if (hold) begin
         @(negedge clk);
         total++;
         if ({m1_req_ready, m0_req_ready} !== 2'b00) begin
            bad++;
            $display("FAIL holdoff_grant: got %b want 00", {m1_req_ready, m0_req_ready});
         end
         cyc();
      end
      hold = 1'b0;
      @(negedge clk);
      total++;
      if ({m1_req_ready, m0_req_ready} !== (w ? 2'b10 : 2'b01)) begin
         bad++;
         $display("FAIL grant: got %b want %b", {m1_req_ready, m0_req_ready}, (w ? 2'b10 : 2'b01));
      end else if (v0 && v1) begin
         cov_tie++;
      end
      total++;
      if ({mem_req_valid, busy} !== 2'b00) begin
         bad++;
         $display("FAIL grant_cycle_idle: got valid/busy %b want 00", {mem_req_valid, busy});
      end
      last_w = w;
      ea  = w ? m1_req_addr  : m0_req_addr;
      ewe = w ? m1_req_we    : m0_req_we;
      ewd = w ? m1_req_wdata : m0_req_wdata;
      ebe = w ? m1_req_be    : m0_req_be;

      for (int i = 0; i <= d; i++) begin
         cyc();
         if (i == 0) begin
            if (w) m1_req_valid = 1'b0;
            else   m0_req_valid = 1'b0;
         end
         mem_req_ready = (i == d);
         s = inj && ($urandom_range(0, 2) == 0);
         mem_rsp_valid = s;
         @(negedge clk);
         total++;
         if ({mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be} !== {1'b1, ea, ewe, ewd, ebe}) begin
            bad++;
            $display("FAIL mem_req: got %h want %h",
                     {mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be}, {1'b1, ea, ewe, ewd, ebe});
         end
         total++;
         if ({m1_req_ready, m0_req_ready, m1_rsp_valid, m0_rsp_valid, stray_rsp_o} !== {4'b0000, s}) begin
            bad++;
            $display("FAIL req_phase: got %b want %b",
                     {m1_req_ready, m0_req_ready, m1_rsp_valid, m0_rsp_valid, stray_rsp_o}, {4'b0000, s});
         end
         if (stray_rsp_o === 1'b1) cov_stray++;
      end

      done = 1'b0;
      for (int k = 0; k <= TO && !done; k++) begin
         cyc();
         rd = use_rd ? force_rd : $urandom;
         re = use_rd ? 1'b0 : 1'($urandom_range(0, 1));
         mem_rsp_valid = (k == r);
         mem_rsp_rdata = rd;
         mem_rsp_err   = re;
         @(negedge clk);
         if (k == r) begin
            exp_v = 1'b1; exp_d = rd;    exp_e = re;   exp_t = 1'b0; done = 1'b1;
         end else if (k == TO) begin
            exp_v = 1'b1; exp_d = 32'd0; exp_e = 1'b1; exp_t = 1'b1; done = 1'b1;
         end else begin
            exp_v = 1'b0; exp_d = 32'd0; exp_e = 1'b0; exp_t = 1'b0;
         end
         own = w ? {m1_rsp_valid, m1_rsp_rdata, m1_rsp_err} : {m0_rsp_valid, m0_rsp_rdata, m0_rsp_err};
         oth = w ? {m0_rsp_valid, m0_rsp_rdata, m0_rsp_err} : {m1_rsp_valid, m1_rsp_rdata, m1_rsp_err};
         total++;
         if (own[33:1] !== {exp_v, exp_d} || (exp_v && own[0] !== exp_e)) begin
            bad++;
            $display("FAIL owner_rsp k=%0d: got %h want v=%b d=%h e=%b", k, own, exp_v, exp_d, exp_e);
         end
         total++;
         if (oth[33:1] !== 33'd0) begin
            bad++;
            $display("FAIL other_rsp k=%0d: got %h want 0", k, oth);
         end
         total++;
         if ({timeout_o, stray_rsp_o, busy} !== {exp_t, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rsp_status k=%0d: got %b want %b", k, {timeout_o, stray_rsp_o, busy}, {exp_t, 1'b0, 1'b1});
         end
         if (timeout_o === 1'b1) cov_to++;
      end
      hold = 1'b1;

      if (late) begin
         cyc();
         mem_rsp_valid = 1'b1;
         mem_rsp_rdata = $urandom;
         mem_rsp_err   = 1'b1;
         @(negedge clk);
         total++;
         if ({stray_rsp_o, timeout_o, m0_rsp_valid, m1_rsp_valid, m0_req_ready, m1_req_ready, busy} !== 7'b1000000) begin
            bad++;
            $display("FAIL late_rsp: got %b want 1000000",
                     {stray_rsp_o, timeout_o, m0_rsp_valid, m1_rsp_valid, m0_req_ready, m1_req_ready, busy});
         end
         if (stray_rsp_o === 1'b1) cov_stray++;
         hold = 1'b0;
      end
   endtask

   task automatic idle_gap(input int n, input bit inj);
      logic s;
      for (int i = 0; i < n; i++) begin
         cyc();
         m0_req_valid = 1'b0;
         m1_req_valid = 1'b0;
         s = inj && ($urandom_range(0, 1) == 1);
         mem_rsp_valid = s;
         mem_rsp_rdata = $urandom;
         @(negedge clk);
         total++;
         if ({stray_rsp_o, busy, m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, timeout_o} !== {s, 6'b0}) begin
            bad++;
            $display("FAIL idle: got %b want %b",
                     {stray_rsp_o, busy, m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, timeout_o}, {s, 6'b0});
         end
         if (stray_rsp_o === 1'b1) cov_stray++;
      end
      if (n > 0) hold = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m0_req_valid = 1'b1; m1_req_valid = 1'b1;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (all_outs() !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", all_outs());
      end
      cyc();
      rst = 1'b0;
      m0_req_valid = 1'b0; m1_req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (all_outs() !== '0) begin
         bad++;
         $display("FAIL post_reset_idle: got %h want 0", all_outs());
      end
      last_w = 1'b1;
      hold = 1'b0;
   endtask

   task automatic test_tie_break();
      m0_req_addr = 32'h0000_0100; m0_req_we = 1'b1; m0_req_wdata = 32'hAAAA_0000; m0_req_be = 4'hF;
      m1_req_addr = 32'h0000_0200; m1_req_we = 1'b1; m1_req_wdata = 32'h5555_0001; m1_req_be = 4'hF;
      for (int i = 0; i < 4; i++) begin
         do_txn(1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_single_read();
      m0_req_addr = 32'h0000_1000; m0_req_we = 1'b0; m0_req_wdata = 32'd0; m0_req_be = 4'hF;
      force_rd = 32'hDEAD_BEEF;
      do_txn(1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_stall();
      m0_req_addr = 32'h0000_2000; m1_req_addr = 32'h0000_3004;
      do_txn(1'b1, 1'b1, 5, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      m1_req_addr = 32'h0000_4008; m1_req_we = 1'b0;
      do_txn(1'b0, 1'b1, 0, TO + 3, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_precedence();
      m0_req_addr = 32'h0000_500C;
      do_txn(1'b1, 1'b0, 1, TO, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      idle_gap(2, 1'b0);
      cyc();
      m1_req_valid = 1'b1; m1_req_addr = 32'h0000_6000;
      @(negedge clk);
      total++;
      if ({m1_req_ready, m0_req_ready} !== 2'b10) begin
         bad++;
         $display("FAIL ar_grant: got %b want 10", {m1_req_ready, m0_req_ready});
      end
      cyc();
      m1_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      cyc();
      #1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL ar_in_rsp: got busy=%b want 1", busy);
      end
      #1;
      rst = 1'b1;
      mem_rsp_valid = 1'b1;
      m0_req_valid = 1'b1;
      #1;
      total++;
      if (all_outs() !== '0) begin
         bad++;
         $display("FAIL ar_outputs: got %h want 0", all_outs());
      end
      cyc();
      rst = 1'b0;
      m0_req_valid = 1'b0;
      last_w = 1'b1;
      hold = 1'b0;
      do_txn(1'b0, 1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [1:0] v;
      int d, r;
      bit late;
      for (int it = 0; it < 30; it++) begin
         m0_req_addr = $urandom; m0_req_we = 1'($urandom_range(0, 1));
         m0_req_wdata = $urandom; m0_req_be = 4'($urandom_range(0, 15));
         m1_req_addr = $urandom; m1_req_we = 1'($urandom_range(0, 1));
         m1_req_wdata = $urandom; m1_req_be = 4'($urandom_range(0, 15));
         v = 2'($urandom_range(1, 3));
         d = $urandom_range(0, 3);
         r = $urandom_range(0, TO + 2);
         late = (r > TO) ? 1'($urandom_range(0, 1)) : 1'b0;
         if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3), 1'b1);
         do_txn(v[0], v[1], d, r, late, 1'b0, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_tie_break();
      test_single_read();
      test_stall();
      test_timeout();
      test_precedence();
      test_async_reset();
      test_random();
      idle_gap(2, 1'b1);
      total++;
      if (cov_tie == 0 || cov_to == 0 || cov_stray == 0) begin
         bad++;
         $display("FAIL coverage: got tie=%0d to=%0d stray=%0d want all nonzero", cov_tie, cov_to, cov_stray);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
